cache_miss_ctrl: RTL

CACHE_MISS_CTRL -- requirements
Module: cache_miss_ctrl

---
 rtl/cache_pkg.sv | 26 ++
 rtl/cache_mem_handshake.sv | 27 ++
 rtl/cache_miss_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared cache definitions: address-split defaults, miss FSM state type, line size.
// Latency: n/a (types and constants only).
// Backpressure: n/a. CACHE_WRITEBACK_EN (optional) enables dirty-victim write-back.
`ifndef CACHE_T
`define CACHE_T 20
`endif
`ifndef CACHE_S
`define CACHE_S 8
`endif
`ifndef CACHE_B
`define CACHE_B 2
`endif

package cache_pkg;

  // Words per cache line for the default build geometry.
  localparam int WORDS = 2 ** `CACHE_B;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2,
    COMMIT    = 2'd3
  } miss_state_t;

endpackage

// File: rtl/cache_mem_handshake.sv
// Memory request front end: presents one word request and flags its completion.
// Latency: combinational; a word completes in the first cycle mem_ready is seen with the request up.
// Backpressure: the request and its address/data stay asserted while mem_ready is low; ready without a request is ignored.
module cache_mem_handshake (
  input  logic        active,
  input  logic        wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        word_done
);

  // Request fields come from registered controller state, so they are stable
  // across wait cycles; everything is forced to zero when no burst is running.
  always_comb begin
    mem_req   = active;
    mem_wen   = active & wen;
    mem_addr  = active ? addr : 32'd0;
    mem_wdata = (active && wen) ? wdata : 32'd0;
    word_done = active & mem_ready;
  end

endmodule

// File: rtl/cache_miss_ctrl.sv
// Cache miss controller: optional victim write-back, line refill, then tag commit.
// Latency: hit resolves in the request cycle; a miss stalls 1 + (bursts x words) memory cycles, then one commit cycle.
// Backpressure: each memory word waits indefinitely for mem_ready; CPU is held by stall. Feature macro: CACHE_WRITEBACK_EN.
module cache_miss_ctrl
  import cache_pkg::*;
#(
  parameter int TAG_WIDTH    = `CACHE_T,
  parameter int SET_WIDTH    = `CACHE_S,
  parameter int OFFSET_WIDTH = `CACHE_B
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  input  logic [31:0]             req_addr,
  input  logic                    hit,
  input  logic                    dirty,
  input  logic [TAG_WIDTH-1:0]    replace_tag,
  output logic                    stall,
  output logic                    repl_en,
  output logic [OFFSET_WIDTH-1:0] line_raddr,
  input  logic [31:0]             line_rdata,
  output logic                    line_fill,
  output logic [OFFSET_WIDTH-1:0] line_waddr,
  output logic [31:0]             line_wdata,
  output logic                    line_commit,
  output logic                    mem_req,
  output logic                    mem_wen,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata,
  input  logic                    mem_ready
);

  localparam int LINE_WORDS = (OFFSET_WIDTH == `CACHE_B) ? WORDS : (2 ** OFFSET_WIDTH);
  localparam logic [OFFSET_WIDTH-1:0] CNT_LAST = OFFSET_WIDTH'(LINE_WORDS - 1);
  localparam int SET_LSB = OFFSET_WIDTH + 2;
  localparam int TAG_LSB = SET_WIDTH + SET_LSB;

  miss_state_t state, state_nxt;
  logic [OFFSET_WIDTH-1:0] cnt;
  logic [TAG_WIDTH-1:0]    req_tag;
  logic [SET_WIDTH-1:0]    req_set;
`ifdef CACHE_WRITEBACK_EN
  logic [TAG_WIDTH-1:0]    victim_tag;
`endif

  logic        miss_start;
  logic        word_done;
  logic        burst_last;
  logic        mem_active;
  logic        mem_wen_int;
  logic [31:0] addr_int;
  logic [31:0] wdata_int;

  // Word offset of the CPU address is irrelevant: bursts always cover the whole line.
  logic unused_offset;
  assign unused_offset = ^req_addr[SET_LSB-1:0];
`ifndef CACHE_WRITEBACK_EN
  logic unused_wb;
  assign unused_wb = ^{dirty, replace_tag, line_rdata};
`endif

  assign miss_start = reset && (state == IDLE) && req_valid && !hit;
  assign burst_last = word_done && (cnt == CNT_LAST);

  // Next-state selection; request inputs only matter in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (miss_start) begin
`ifdef CACHE_WRITEBACK_EN
          state_nxt = dirty ? WRITEBACK : REFILL;
`else
          state_nxt = REFILL;
`endif
        end
      end
`ifdef CACHE_WRITEBACK_EN
      WRITEBACK: if (burst_last) state_nxt = REFILL;
`endif
      REFILL:    if (burst_last) state_nxt = COMMIT;
      COMMIT:    state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // State, word counter and latched miss address; reset abandons any burst in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      req_tag <= '0;
      req_set <= '0;
`ifdef CACHE_WRITEBACK_EN
      victim_tag <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (miss_start) begin
        cnt     <= '0;
        req_tag <= req_addr[31 -: TAG_WIDTH];
        req_set <= req_addr[TAG_LSB-1 -: SET_WIDTH];
`ifdef CACHE_WRITEBACK_EN
        victim_tag <= replace_tag;
`endif
      end else if (word_done) begin
        cnt <= burst_last ? '0 : cnt + 1'b1;
      end
    end
  end

  // Memory request contents for the current burst word.
  always_comb begin
    mem_active  = 1'b0;
    mem_wen_int = 1'b0;
    addr_int    = 32'd0;
    wdata_int   = 32'd0;
    if (reset) begin
      case (state)
`ifdef CACHE_WRITEBACK_EN
        WRITEBACK: begin
          mem_active  = 1'b1;
          mem_wen_int = 1'b1;
          addr_int    = {victim_tag, req_set, cnt, 2'b00};
          wdata_int   = line_rdata;
        end
`endif
        REFILL: begin
          mem_active = 1'b1;
          addr_int   = {req_tag, req_set, cnt, 2'b00};
        end
        default: ;
      endcase
    end
  end

  cache_mem_handshake u_mem_handshake (
    .active    (mem_active),
    .wen       (mem_wen_int),
    .addr      (addr_int),
    .wdata     (wdata_int),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .word_done (word_done)
  );

  // Line-array strobes and CPU status; all held at zero while reset is low.
  always_comb begin
    line_fill   = reset && (state == REFILL) && word_done;
    line_waddr  = line_fill ? cnt : '0;
    line_wdata  = line_fill ? mem_rdata : 32'd0;
`ifdef CACHE_WRITEBACK_EN
    line_raddr  = (reset && (state == WRITEBACK)) ? cnt : '0;
`else
    line_raddr  = '0;
`endif
    line_commit = reset && (state == COMMIT);
    repl_en     = line_commit || (reset && (state == IDLE) && req_valid && hit);
    stall       = miss_start || (reset && ((state == WRITEBACK) || (state == REFILL)));
  end

endmodule
